// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start / soft-stop sequencer acting as the sole local-bus
// write master of the PWM register block. A ramp enables the chosen channel,
// steps its duty towards a target with one write every INTERVAL clocks and, for
// a ramp that ends at 0, optionally disables the channel again. The duty last
// written to each channel is kept in a shadow register.
//
// Ports:
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   START_I        one-cycle ramp request, honoured only when idle
//   CH_SEL_I       channel select (0/1), latched with START_I
//   TARGET_DUTY_I  target duty (clamped to 1000), latched with START_I
//   STEP_I         duty step (0 treated as 1), latched with START_I
//   INTERVAL_I     clocks between duty writes (0 treated as 1), latched with START_I
//   ABORT_I        stop the ramp, no further writes
//   LB_WADDR       registered write address
//   LB_WDATA       registered write data (zero-extended)
//   LB_WREQ        registered one-cycle write strobe
//   BUSY_O         high whenever not idle
//   DONE_O         one-cycle pulse on normal completion
//   CUR_DUTY_O     shadow duty of the latched channel
module pwm_ramp_ctrl #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 16,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter logic [9:0]  DEFAULT_DUTY_CH0   = 10'd0,
  parameter logic [9:0]  DEFAULT_DUTY_CH1   = 10'd0,
  parameter bit          DISABLE_AT_ZERO    = 1'b1
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          START_I,
  input  logic                          CH_SEL_I,
  input  logic [9:0]                    TARGET_DUTY_I,
  input  logic [9:0]                    STEP_I,
  input  logic [15:0]                   INTERVAL_I,
  input  logic                          ABORT_I,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] LB_WADDR,
  output logic [C_S_AXI_DATA_WIDTH-1:0] LB_WDATA,
  output logic                          LB_WREQ,
  output logic                          BUSY_O,
  output logic                          DONE_O,
  output logic [9:0]                    CUR_DUTY_O
);

  localparam logic [9:0] MAX_DUTY = 10'd1000;

  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_EN_CH0   = C_S_AXI_ADDR_WIDTH'(16'h0000);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_DUTY_CH0 = C_S_AXI_ADDR_WIDTH'(16'h0008);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_EN_CH1   = C_S_AXI_ADDR_WIDTH'(16'h000C);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_DUTY_CH1 = C_S_AXI_ADDR_WIDTH'(16'h0014);

  typedef enum logic [2:0] {
    StIdle,
    StEnWr,
    StStepWr,
    StWait,
    StDisWr,
    StDone
  } state_e;

  state_e r_state, w_state_d;

  logic        r_ch, w_ch_d;
  logic [9:0]  r_target, w_target_d;
  logic [9:0]  r_step, w_step_d;
  logic [15:0] r_interval, w_interval_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [9:0]  r_duty0, w_duty0_d;
  logic [9:0]  r_duty1, w_duty1_d;
  logic        r_wreq, w_wreq_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_waddr, w_waddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata, w_wdata_d;

  logic [9:0]  w_cur;
  logic [9:0]  w_next;
  logic [10:0] w_up_sum;
  logic [10:0] w_dn_floor;
  logic        w_do_step;

  assign w_cur = r_ch ? r_duty1 : r_duty0;

  // Next duty with 11-bit sums so neither direction can wrap: stepping up stops
  // at target once cur+step reaches it, stepping down once cur <= target+step.
  always_comb begin
    w_up_sum   = {1'b0, w_cur} + {1'b0, r_step};
    w_dn_floor = {1'b0, r_target} + {1'b0, r_step};
    w_next     = w_cur;
    if (w_cur < r_target) begin
      w_next = (w_up_sum >= {1'b0, r_target}) ? r_target : w_up_sum[9:0];
    end else if (w_cur > r_target) begin
      w_next = ({1'b0, w_cur} <= w_dn_floor) ? r_target : (w_cur - r_step);
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_ch_d       = r_ch;
    w_target_d   = r_target;
    w_step_d     = r_step;
    w_interval_d = r_interval;
    w_cnt_d      = r_cnt;
    w_duty0_d    = r_duty0;
    w_duty1_d    = r_duty1;
    w_wreq_d     = 1'b0;
    w_waddr_d    = r_waddr;
    w_wdata_d    = r_wdata;
    w_do_step    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (START_I) begin
          w_ch_d       = CH_SEL_I;
          w_target_d   = (TARGET_DUTY_I > MAX_DUTY) ? MAX_DUTY : TARGET_DUTY_I;
          w_step_d     = (STEP_I == 10'd0) ? 10'd1 : STEP_I;
          w_interval_d = (INTERVAL_I == 16'd0) ? 16'd1 : INTERVAL_I;
          w_wreq_d     = 1'b1;
          w_waddr_d    = CH_SEL_I ? ADDR_EN_CH1 : ADDR_EN_CH0;
          w_wdata_d    = C_S_AXI_DATA_WIDTH'(1);
          w_state_d    = StEnWr;
        end
      end
      StEnWr: begin
        w_do_step = 1'b1;
        w_state_d = StStepWr;
      end
      // The shadow already holds the value being written this cycle.
      StStepWr: begin
        if (w_cur == r_target) begin
          if (DISABLE_AT_ZERO && (r_target == 10'd0)) begin
            w_wreq_d  = 1'b1;
            w_waddr_d = r_ch ? ADDR_EN_CH1 : ADDR_EN_CH0;
            w_wdata_d = '0;
            w_state_d = StDisWr;
          end else begin
            w_state_d = StDone;
          end
        end else if (r_interval == 16'd1) begin
          // Interval of one: back-to-back duty writes, no wait state.
          w_do_step = 1'b1;
        end else begin
          w_cnt_d   = r_interval - 16'd1;
          w_state_d = StWait;
        end
      end
      // Counter is loaded with INTERVAL-1; the write lands as it reaches zero.
      StWait: begin
        if (r_cnt <= 16'd1) begin
          w_cnt_d   = '0;
          w_do_step = 1'b1;
          w_state_d = StStepWr;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StDisWr: w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (w_do_step) begin
      w_wreq_d  = 1'b1;
      w_waddr_d = r_ch ? ADDR_DUTY_CH1 : ADDR_DUTY_CH0;
      w_wdata_d = C_S_AXI_DATA_WIDTH'(w_next);
      if (r_ch) begin
        w_duty1_d = w_next;
      end else begin
        w_duty0_d = w_next;
      end
    end

    // Abort wins over everything outside idle: drop any pending write and
    // leave the shadows at the last value that actually reached the bus.
    if (ABORT_I && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_wreq_d  = 1'b0;
      w_waddr_d = r_waddr;
      w_wdata_d = r_wdata;
      w_duty0_d = r_duty0;
      w_duty1_d = r_duty1;
      w_cnt_d   = '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state    <= StIdle;
      r_ch       <= 1'b0;
      r_target   <= '0;
      r_step     <= '0;
      r_interval <= '0;
      r_cnt      <= '0;
      r_duty0    <= DEFAULT_DUTY_CH0;
      r_duty1    <= DEFAULT_DUTY_CH1;
      r_wreq     <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_ch       <= w_ch_d;
      r_target   <= w_target_d;
      r_step     <= w_step_d;
      r_interval <= w_interval_d;
      r_cnt      <= w_cnt_d;
      r_duty0    <= w_duty0_d;
      r_duty1    <= w_duty1_d;
      r_wreq     <= w_wreq_d;
      r_waddr    <= w_waddr_d;
      r_wdata    <= w_wdata_d;
    end
  end

  assign LB_WREQ    = r_wreq;
  assign LB_WADDR   = r_waddr;
  assign LB_WDATA   = r_wdata;
  assign BUSY_O     = (r_state != StIdle);
  assign DONE_O     = (r_state == StDone);
  assign CUR_DUTY_O = w_cur;

endmodule
